gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Synthesizable response checker for the bitwise gate library: the consuming end of the A/B → F vector interface that benches drive into gate DUTs.
- Accepts {A, B, F} triples through a valid/ready handshake and recomputes the expected F for the selected operation.
- Counts passes and failures and captures the first mismatch.
- Used on-chip as a BIST monitor and in benches in place of waveform inspection.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 16, width of all counters and the index output.
- NUM_VEC, 0, vectors per run; 0 means unbounded, so the run ends only on STOP.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- START  in  1  single-cycle pulse; latches OP and starts a run.
- STOP  in  1  single-cycle pulse; ends the run.
- OP  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- VALID  in  1  the A/B/F triple is valid this cycle.
- READY  out  1  checker accepts a triple this cycle.
- A  in  WIDTH  operand A applied to the DUT.
- B  in  WIDTH  operand B applied to the DUT.
- F  in  WIDTH  DUT output.
- PASS_CNT  out  CNT_W  matching vectors in the current run.
- FAIL_CNT  out  CNT_W  mismatching vectors in the current run.
- FIRST_FAIL_IDX  out  CNT_W  index of the first mismatch (0-based).
- FIRST_FAIL_MASK  out  WIDTH  expected XOR F for the first mismatch.
- BUSY  out  1  high in RUN and while the compare stage is still full.
- DONE  out  1  high in DONE state.
- RESULT_OK  out  1  DONE and FAIL_CNT==0.

Behaviour:
- Reset (asynchronous, RST_N=0): state IDLE; every output 0, including READY, counters, index, mask, BUSY, DONE and RESULT_OK. Internal compare-stage valid flag and OP register are 0.
- States:
  - IDLE → RUN on START. In the same edge: OP is latched; counters, index, mask and vector index are cleared.
  - RUN: READY=1. STOP → DONE. Vector index reaching NUM_VEC (when NUM_VEC≠0) → DONE.
  - DONE: READY=0. START → RUN with the same clearing as IDLE→RUN.
- START while in RUN: ignored. OP changes during a run: ignored; the latched value is used.
- Accept: a triple is accepted on an edge where VALID&READY=1. Stage 1 registers A, B, F and the current vector index, then increments the vector index.
- Compare: stage 2, on the following edge, computes expected = op(A,B) and updates the counters.
- Latency: accept to counter visible is 2 edges.
- Mismatch (expected≠F):
  - FAIL_CNT increments.
  - On the first failure of a run only, FIRST_FAIL_IDX and FIRST_FAIL_MASK are captured; they are not overwritten afterwards.
- Match: PASS_CNT increments.
- Counters saturate at all-ones and never wrap.
- STOP and VALID in the same cycle: the vector is accepted and counted.
- Final-vector acceptance and the RUN→DONE transition happen on the same edge. DONE asserts when the state is DONE. BUSY stays high until the compare stage drains, one edge later.
- RESULT_OK is registered and valid once BUSY=0 in DONE.
- RST_N asserted mid-run: immediate return to IDLE. Partial results are discarded; no DONE is produced.
- NAND expected = ~(A&B), masked to WIDTH bits. All arithmetic is unsigned.

Optional Feature:
- Macro: GATE_CHK_ERR_IRQ_EN.
- Defined:
  - Adds output ERR_IRQ (1 bit). ERR_IRQ is a registered single-cycle pulse on the edge a mismatch is counted, and it pulses on every mismatch.
  - Adds input IRQ_MASK (1 bit); while IRQ_MASK=1, ERR_IRQ is held 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package gate_chk_pkg:
  - OP encodings OP_AND, OP_OR, OP_XOR, OP_NAND (2-bit).
  - State encoding ST_IDLE, ST_RUN, ST_DONE (2-bit).
- Sub-module gate_ref_model: purely combinational, inputs OP/A/B, output expected, parameterised WIDTH. It is shared with future checkers for the other gates.
- Top module holds the FSM, the two-stage pipeline, the counters and the capture registers.

Test Plan:
- AND, NUM_VEC=0; correct F for (00,00), (FF,01), (00,FF), (FF,FF), (59,BE), (AA,72), then STOP → PASS_CNT=6, FAIL_CNT=0, DONE=1, RESULT_OK=1.
- AND, NUM_VEC=0; vector 3 sent as (59,BE) with F=0x19 instead of 0x18, other vectors correct, then STOP → FAIL_CNT=1, FIRST_FAIL_IDX=3, FIRST_FAIL_MASK=0x01, RESULT_OK=0.
- XOR with NUM_VEC=4; 4 correct vectors on back-to-back VALID → DONE on the 4th accept edge; a 5th VALID is not accepted (READY=0); PASS_CNT=4.
- NAND, (FF,FF) with F=0x00, STOP asserted in the same cycle as VALID → vector counted, PASS_CNT=1; BUSY drops one edge after DONE.
- RST_N pulled low two cycles into a run, after 2 accepts → all outputs 0 immediately; START afterwards begins a clean run with counters 0.
- CNT_W=2, 5 failing vectors → FAIL_CNT saturates at 3; FIRST_FAIL_IDX=0 is unchanged. With GATE_CHK_ERR_IRQ_EN defined: 5 ERR_IRQ pulses, and 0 pulses when IRQ_MASK=1.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate vector checker family.
package gate_chk_pkg;

  // Operation select encoding applied to the gate under test
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  // Checker run state
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the bitwise gate library: expected result for op(a, b).
module gate_ref_model
  import gate_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected_c
);

  // Select the gate function; NAND stays inside WIDTH bits by construction
  always_comb begin
    expected_c = '0;
    case (op)
      OP_AND:  expected_c = a & b;
      OP_OR:   expected_c = a | b;
      OP_XOR:  expected_c = a ^ b;
      OP_NAND: expected_c = ~(a & b);
      default: expected_c = '0;
    endcase
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Response checker: accepts {A,B,F} triples, recomputes F, counts pass/fail and
// captures the first mismatch. Optional error interrupt under GATE_CHK_ERR_IRQ_EN.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned NUM_VEC = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       OP,
  input  logic             VALID,
  output logic             READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] F,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic [CNT_W-1:0] FIRST_FAIL_IDX,
  output logic [WIDTH-1:0] FIRST_FAIL_MASK,
  output logic             BUSY,
  output logic             DONE,
  output logic             RESULT_OK
`ifdef GATE_CHK_ERR_IRQ_EN
  ,
  input  logic             IRQ_MASK,
  output logic             ERR_IRQ
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((NUM_VEC == 0) ? 0 : NUM_VEC - 1);

  state_e           state_q, state_d;
  op_e              op_q;
  logic             start_fire, accept, last_vec;
  logic [CNT_W-1:0] vec_idx_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_f_q;
  logic [CNT_W-1:0] s1_idx_q;
  logic [WIDTH-1:0] expected_c;
  logic             mismatch_c, compare_c;
  logic [CNT_W-1:0] pass_d, fail_d, idx_d;
  logic [WIDTH-1:0] mask_d;

  assign start_fire = START && (state_q != ST_RUN);
  assign accept     = VALID && READY;
  assign last_vec   = (NUM_VEC != 0) && (vec_idx_q == LAST_IDX);

  // Run control: start, explicit stop, or final bounded vector
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_RUN;
      ST_RUN:  if (STOP || (accept && last_vec)) state_d = ST_DONE;
      ST_DONE: if (START) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op         (op_q),
    .a          (s1_a_q),
    .b          (s1_b_q),
    .expected_c (expected_c)
  );

  assign mismatch_c = (expected_c != s1_f_q);
  // A start discards whatever the compare stage holds
  assign compare_c  = s1_valid_q && !start_fire;

  // Stage-2 result update with saturating counters and first-fail capture
  always_comb begin
    pass_d = PASS_CNT;
    fail_d = FAIL_CNT;
    idx_d  = FIRST_FAIL_IDX;
    mask_d = FIRST_FAIL_MASK;
    if (start_fire) begin
      pass_d = '0;
      fail_d = '0;
      idx_d  = '0;
      mask_d = '0;
    end else if (compare_c) begin
      if (mismatch_c) begin
        if (FAIL_CNT == '0) begin
          idx_d  = s1_idx_q;
          mask_d = expected_c ^ s1_f_q;
        end
        if (FAIL_CNT != CNT_MAX) fail_d = FAIL_CNT + CNT_W'(1);
      end else if (PASS_CNT != CNT_MAX) begin
        pass_d = PASS_CNT + CNT_W'(1);
      end
    end
  end

  // State register and registered status outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_AND;
      READY     <= 1'b0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
      RESULT_OK <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (start_fire) op_q <= op_e'(OP);
      READY     <= (state_d == ST_RUN);
      DONE      <= (state_d == ST_DONE);
      BUSY      <= (state_d == ST_RUN) || accept;
      RESULT_OK <= (state_d == ST_DONE) && !accept && (fail_d == '0);
    end
  end

  // Stage 1: capture the accepted triple and its vector index
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vec_idx_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_f_q     <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (start_fire) begin
        vec_idx_q <= '0;
      end else if (accept) begin
        s1_a_q   <= A;
        s1_b_q   <= B;
        s1_f_q   <= F;
        s1_idx_q <= vec_idx_q;
        if (vec_idx_q != CNT_MAX) vec_idx_q <= vec_idx_q + CNT_W'(1);
      end
    end
  end

  // Result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PASS_CNT        <= '0;
      FAIL_CNT        <= '0;
      FIRST_FAIL_IDX  <= '0;
      FIRST_FAIL_MASK <= '0;
    end else begin
      PASS_CNT        <= pass_d;
      FAIL_CNT        <= fail_d;
      FIRST_FAIL_IDX  <= idx_d;
      FIRST_FAIL_MASK <= mask_d;
    end
  end

`ifdef GATE_CHK_ERR_IRQ_EN
  // One-cycle pulse per counted mismatch, suppressed while masked
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ERR_IRQ <= 1'b0;
    else        ERR_IRQ <= compare_c && mismatch_c && !IRQ_MASK;
  end
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench for gate_vector_checker: three instances (unbounded, NUM_VEC=4, CNT_W=2).
`timescale 1ns/1ps
module tb_gate_vector_checker;

  typedef struct {
    int          due;
    logic [15:0] pass;
    logic [15:0] fail;
    logic [15:0] idx;
    logic [7:0]  mask;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  op;
  logic [7:0]  a, b, f;
  logic [2:0]  start_v, stop_v, valid_v;

  logic        rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2, ok0, ok1, ok2;
  logic [15:0] pc0, pc1, fc0, fc1, ix0, ix1;
  logic [1:0]  pc2, fc2, ix2;
  logic [7:0]  mk0, mk1, mk2;

  logic        c_rdy, c_busy, c_done, c_ok;
  logic [15:0] c_pass, c_fail, c_idx;
  logic [7:0]  c_mask;

`ifdef GATE_CHK_ERR_IRQ_EN
  logic        irq_mask;
  logic        irq0, irq1, irq2, c_irq;
  int          irq_seen;
`endif

  int          sel;
  int          cyc;
  int          n_checks;
  int          n_pass;
  exp_t        sb[$];
  logic [1:0]  op_m;
  int          m_vec;
  logic [15:0] m_pass, m_fail, m_idx, cmax;
  logic [7:0]  m_mask;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_vector_checker #(.WIDTH(8), .CNT_W(16), .NUM_VEC(0)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start_v[0]), .STOP(stop_v[0]), .OP(op),
    .VALID(valid_v[0]), .READY(rdy0), .A(a), .B(b), .F(f),
    .PASS_CNT(pc0), .FAIL_CNT(fc0), .FIRST_FAIL_IDX(ix0), .FIRST_FAIL_MASK(mk0),
    .BUSY(bsy0), .DONE(dn0), .RESULT_OK(ok0)
`ifdef GATE_CHK_ERR_IRQ_EN
    , .IRQ_MASK(irq_mask), .ERR_IRQ(irq0)
`endif
  );

  gate_vector_checker #(.WIDTH(8), .CNT_W(16), .NUM_VEC(4)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start_v[1]), .STOP(stop_v[1]), .OP(op),
    .VALID(valid_v[1]), .READY(rdy1), .A(a), .B(b), .F(f),
    .PASS_CNT(pc1), .FAIL_CNT(fc1), .FIRST_FAIL_IDX(ix1), .FIRST_FAIL_MASK(mk1),
    .BUSY(bsy1), .DONE(dn1), .RESULT_OK(ok1)
`ifdef GATE_CHK_ERR_IRQ_EN
    , .IRQ_MASK(irq_mask), .ERR_IRQ(irq1)
`endif
  );

  gate_vector_checker #(.WIDTH(8), .CNT_W(2), .NUM_VEC(0)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start_v[2]), .STOP(stop_v[2]), .OP(op),
    .VALID(valid_v[2]), .READY(rdy2), .A(a), .B(b), .F(f),
    .PASS_CNT(pc2), .FAIL_CNT(fc2), .FIRST_FAIL_IDX(ix2), .FIRST_FAIL_MASK(mk2),
    .BUSY(bsy2), .DONE(dn2), .RESULT_OK(ok2)
`ifdef GATE_CHK_ERR_IRQ_EN
    , .IRQ_MASK(irq_mask), .ERR_IRQ(irq2)
`endif
  );

  // Route the selected instance's outputs to a common view
  always_comb begin
    c_rdy = rdy0; c_busy = bsy0; c_done = dn0; c_ok = ok0;
    c_pass = pc0; c_fail = fc0; c_idx = ix0; c_mask = mk0;
`ifdef GATE_CHK_ERR_IRQ_EN
    c_irq = irq0;
`endif
    if (sel == 1) begin
      c_rdy = rdy1; c_busy = bsy1; c_done = dn1; c_ok = ok1;
      c_pass = pc1; c_fail = fc1; c_idx = ix1; c_mask = mk1;
`ifdef GATE_CHK_ERR_IRQ_EN
      c_irq = irq1;
`endif
    end else if (sel == 2) begin
      c_rdy = rdy2; c_busy = bsy2; c_done = dn2; c_ok = ok2;
      c_pass = 16'(pc2); c_fail = 16'(fc2); c_idx = 16'(ix2); c_mask = mk2;
`ifdef GATE_CHK_ERR_IRQ_EN
      c_irq = irq2;
`endif
    end
  end

  function automatic logic [7:0] gate_fn(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_run(input int s, input logic [1:0] o);
    sel = s; op = o; op_m = o;
    m_vec = 0; m_pass = '0; m_fail = '0; m_idx = '0; m_mask = '0;
    cmax = (s == 2) ? 16'd3 : 16'hFFFF;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = '0;
    check("ready_after_start", 32'(c_rdy), 32'd1);
    check("pass_clear_on_start", 32'(c_pass), 32'd0);
  endtask

  // Drive one triple for a cycle; model and push only if it will be accepted
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] fv, input logic stp);
    exp_t       e;
    logic [7:0] ex;
    a = av; b = bv; f = fv;
    valid_v[sel] = 1'b1;
    stop_v[sel]  = stp;
    if (c_rdy) begin
      ex = gate_fn(op_m, av, bv);
      if (ex != fv) begin
        if (m_fail == 16'd0) begin
          m_idx  = 16'(m_vec);
          m_mask = ex ^ fv;
        end
        if (m_fail != cmax) m_fail = m_fail + 16'd1;
      end else if (m_pass != cmax) begin
        m_pass = m_pass + 16'd1;
      end
      m_vec++;
      e.due = cyc + 2; e.pass = m_pass; e.fail = m_fail; e.idx = m_idx; e.mask = m_mask;
      sb.push_back(e);
    end
    @(negedge clk);
    valid_v = '0;
    stop_v  = '0;
  endtask

  task automatic stop_pulse();
    stop_v[sel] = 1'b1;
    @(negedge clk);
    stop_v = '0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; op = 2'b00; a = '0; b = '0; f = '0;
    start_v = '0; stop_v = '0; valid_v = '0;
    sel = 0; cyc = 0; n_checks = 0; n_pass = 0; op_m = 2'b00;
    m_vec = 0; m_pass = '0; m_fail = '0; m_idx = '0; m_mask = '0; cmax = 16'hFFFF;
`ifdef GATE_CHK_ERR_IRQ_EN
    irq_mask = 1'b0; irq_seen = 0;
`endif

    fork
      // Cycle counter and scoreboard pop, two edges after each accept
      forever begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check("sb_pass_cnt", 32'(c_pass), 32'(e.pass));
          check("sb_fail_cnt", 32'(c_fail), 32'(e.fail));
          check("sb_first_idx", 32'(c_idx), 32'(e.idx));
          check("sb_first_mask", 32'(c_mask), 32'(e.mask));
        end
`ifdef GATE_CHK_ERR_IRQ_EN
        if (c_irq) irq_seen++;
`endif
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(c_rdy), 32'd0);
    check("rst_busy", 32'(c_busy), 32'd0);
    check("rst_done", 32'(c_done), 32'd0);
    check("rst_result_ok", 32'(c_ok), 32'd0);
    check("rst_pass", 32'(c_pass), 32'd0);
    check("rst_fail", 32'(c_fail), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AND, all correct; OP wiggled mid-run must be ignored
    start_run(0, 2'b00);
    op = 2'b10;
    send(8'h00, 8'h00, 8'h00, 1'b0);
    send(8'hFF, 8'h01, 8'h01, 1'b0);
    send(8'h00, 8'hFF, 8'h00, 1'b0);
    send(8'hFF, 8'hFF, 8'hFF, 1'b0);
    send(8'h59, 8'hBE, 8'h18, 1'b0);
    send(8'hAA, 8'h72, 8'h22, 1'b0);
    stop_pulse();
    drain();
    check("t1_pass", 32'(c_pass), 32'd6);
    check("t1_fail", 32'(c_fail), 32'd0);
    check("t1_done", 32'(c_done), 32'd1);
    check("t1_result_ok", 32'(c_ok), 32'd1);
    check("t1_busy", 32'(c_busy), 32'd0);
    check("t1_ready", 32'(c_rdy), 32'd0);

    // AND, vector 3 wrong by one bit; restart from DONE
    start_run(0, 2'b00);
    send(8'h00, 8'h00, 8'h00, 1'b0);
    send(8'hFF, 8'h01, 8'h01, 1'b0);
    send(8'h00, 8'hFF, 8'h00, 1'b0);
    send(8'h59, 8'hBE, 8'h19, 1'b0);
    send(8'hFF, 8'hFF, 8'hFF, 1'b0);
    send(8'hAA, 8'h72, 8'h22, 1'b0);
    stop_pulse();
    drain();
    check("t2_fail", 32'(c_fail), 32'd1);
    check("t2_pass", 32'(c_pass), 32'd5);
    check("t2_first_idx", 32'(c_idx), 32'd3);
    check("t2_first_mask", 32'(c_mask), 32'h01);
    check("t2_result_ok", 32'(c_ok), 32'd0);

    // XOR, NUM_VEC=4, back-to-back; 5th VALID refused
    start_run(1, 2'b10);
    send(8'h12, 8'h34, 8'h26, 1'b0);
    send(8'hFF, 8'h0F, 8'hF0, 1'b0);
    send(8'hA5, 8'h5A, 8'hFF, 1'b0);
    send(8'h00, 8'h00, 8'h00, 1'b0);
    check("t3_done_on_last", 32'(c_done), 32'd1);
    check("t3_ready_low", 32'(c_rdy), 32'd0);
    check("t3_busy_draining", 32'(c_busy), 32'd1);
    send(8'h01, 8'h01, 8'h00, 1'b0);
    check("t3_busy_drained", 32'(c_busy), 32'd0);
    drain();
    check("t3_pass", 32'(c_pass), 32'd4);
    check("t3_result_ok", 32'(c_ok), 32'd1);

    // NAND, STOP together with VALID
    start_run(0, 2'b11);
    send(8'hFF, 8'hFF, 8'h00, 1'b1);
    check("t4_done", 32'(c_done), 32'd1);
    check("t4_busy_full", 32'(c_busy), 32'd1);
    @(negedge clk);
    check("t4_busy_drop", 32'(c_busy), 32'd0);
    check("t4_result_ok", 32'(c_ok), 32'd1);
    drain();
    check("t4_pass", 32'(c_pass), 32'd1);

    // Reset mid-run after two accepts
    start_run(0, 2'b00);
    send(8'h0F, 8'hFF, 8'h0F, 1'b0);
    send(8'hF0, 8'hFF, 8'hF0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("t5_pass_zero", 32'(c_pass), 32'd0);
    check("t5_fail_zero", 32'(c_fail), 32'd0);
    check("t5_ready_zero", 32'(c_rdy), 32'd0);
    check("t5_busy_zero", 32'(c_busy), 32'd0);
    check("t5_done_zero", 32'(c_done), 32'd0);
    check("t5_idx_zero", 32'(c_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(0, 2'b01);
    send(8'h0F, 8'hF0, 8'hFF, 1'b0);
    drain();
    check("t5_clean_pass", 32'(c_pass), 32'd1);
    check("t5_clean_fail", 32'(c_fail), 32'd0);

    // CNT_W=2: five failures saturate the counter
`ifdef GATE_CHK_ERR_IRQ_EN
    irq_seen = 0;
`endif
    start_run(2, 2'b00);
    for (int i = 0; i < 5; i++) send(8'hFF, 8'hFF, 8'h00, 1'b0);
    drain();
    check("t6_fail_sat", 32'(c_fail), 32'd3);
    check("t6_first_idx", 32'(c_idx), 32'd0);
    check("t6_first_mask", 32'(c_mask), 32'hFF);
    check("t6_pass", 32'(c_pass), 32'd0);
`ifdef GATE_CHK_ERR_IRQ_EN
    check("t6_irq_pulses", 32'(irq_seen), 32'd5);
    stop_pulse();
    irq_mask = 1'b1;
    irq_seen = 0;
    start_run(2, 2'b00);
    for (int i = 0; i < 5; i++) send(8'hFF, 8'hFF, 8'h00, 1'b0);
    drain();
    check("t6_irq_masked", 32'(irq_seen), 32'd0);
    check("t6_fail_sat_masked", 32'(c_fail), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
